usequencer_stack: RTL and testbench

Microprogram sequencer for the microcoded datapath. Each clock it computes the next control-store address from the MIR condition field, the MIR jump field, the PSR flags and the IR decode fields. It generalises the classic next/jump/decode scheme with parametrised address width, a microsubroutine return stack (call/return) and a memory-wait condition. Its registered output drives the control-store ROM address; the ROM output feeds the MIR in the datapath.

---
 rtl/usequencer_stack.sv | 145 ++++++++++++++
 tb/tb_usequencer_stack.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/usequencer_stack.sv
// Microprogram sequencer: picks the next control-store address from MIR COND/JUMP, PSR flags and IR decode, with a call/return stack.
// Latency: one clock from the MIR fields and flags to the new registered control-store address.
// Backpressure: none; WAIT holds the address until main memory reports the access complete.
module usequencer_stack #(
    parameter int ADDR_WIDTH  = 11,
    parameter int COND_WIDTH  = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SP_WIDTH    = 3,
    parameter int RESET_ADDR  = 0
) (
    input  logic                  uSequencer_CLOCK_50,
    input  logic                  uSequencer_Reset_InHigh,
    input  logic [COND_WIDTH-1:0] uSequencer_Cond_In,
    input  logic [ADDR_WIDTH-1:0] uSequencer_JumpAddr_In,
    input  logic                  uSequencer_FlagN_In,
    input  logic                  uSequencer_FlagZ_In,
    input  logic                  uSequencer_FlagV_In,
    input  logic                  uSequencer_FlagC_In,
    input  logic [1:0]            uSequencer_IR_OP_In,
    input  logic [2:0]            uSequencer_IR_OP2_In,
    input  logic [5:0]            uSequencer_IR_OP3_In,
    input  logic                  uSequencer_IR_BIT13_In,
    input  logic                  uSequencer_MemReady_InHigh,
    output logic [ADDR_WIDTH-1:0] uSequencer_CSAddr_Out,
    output logic [SP_WIDTH-1:0]   uSequencer_StackDepth_Out,
    output logic                  uSequencer_StackErr_OutHigh
);

    localparam logic [COND_WIDTH-1:0] C_NEXT   = COND_WIDTH'(0);
    localparam logic [COND_WIDTH-1:0] C_JN     = COND_WIDTH'(1);
    localparam logic [COND_WIDTH-1:0] C_JZ     = COND_WIDTH'(2);
    localparam logic [COND_WIDTH-1:0] C_JV     = COND_WIDTH'(3);
    localparam logic [COND_WIDTH-1:0] C_JC     = COND_WIDTH'(4);
    localparam logic [COND_WIDTH-1:0] C_JIR13  = COND_WIDTH'(5);
    localparam logic [COND_WIDTH-1:0] C_JUMP   = COND_WIDTH'(6);
    localparam logic [COND_WIDTH-1:0] C_DECODE = COND_WIDTH'(7);
    localparam logic [COND_WIDTH-1:0] C_CALL   = COND_WIDTH'(8);
    localparam logic [COND_WIDTH-1:0] C_RET    = COND_WIDTH'(9);
    localparam logic [COND_WIDTH-1:0] C_WAIT   = COND_WIDTH'(10);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [SP_WIDTH-1:0]   r_sp;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] w_inc;
    logic [ADDR_WIDTH-1:0] w_next;
    logic [ADDR_WIDTH-1:0] w_top;
    logic [ADDR_WIDTH-1:0] w_dec;
    logic [10:0]           w_dec_low;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_err_set;

    assign w_inc   = r_addr + ADDR_WIDTH'(1);
    assign w_full  = (r_sp >= SP_WIDTH'(STACK_DEPTH));
    assign w_empty = (r_sp == '0);

    // Decode target: 11-bit dispatch address built from the IR opcode fields, zero-extended.
    always_comb begin
        w_dec_low = 11'h500;
        case (uSequencer_IR_OP_In)
            2'd0:    w_dec_low = {1'b1, 2'b00, 3'b000, uSequencer_IR_OP2_In, 2'b00};
            2'd1:    w_dec_low = 11'h500;
            default: w_dec_low = {1'b1, uSequencer_IR_OP_In, uSequencer_IR_OP3_In, 2'b00};
        endcase
        w_dec = ADDR_WIDTH'(w_dec_low);
    end

    // Top-of-stack read: entry at depth-1, selected by comparing against each slot index.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SP_WIDTH'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    // Next-address select; a suppressed call or empty return falls through to INC and flags an error.
    always_comb begin
        w_next    = w_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        case (uSequencer_Cond_In)
            C_NEXT:   w_next = w_inc;
            C_JN:     if (uSequencer_FlagN_In)    w_next = uSequencer_JumpAddr_In;
            C_JZ:     if (uSequencer_FlagZ_In)    w_next = uSequencer_JumpAddr_In;
            C_JV:     if (uSequencer_FlagV_In)    w_next = uSequencer_JumpAddr_In;
            C_JC:     if (uSequencer_FlagC_In)    w_next = uSequencer_JumpAddr_In;
            C_JIR13:  if (uSequencer_IR_BIT13_In) w_next = uSequencer_JumpAddr_In;
            C_JUMP:   w_next = uSequencer_JumpAddr_In;
            C_DECODE: w_next = w_dec;
            C_CALL: begin
                if (w_full) begin
                    w_err_set = 1'b1;
                end else begin
                    w_push = 1'b1;
                    w_next = uSequencer_JumpAddr_In;
                end
            end
            C_RET: begin
                if (w_empty) begin
                    w_err_set = 1'b1;
                end else begin
                    w_pop  = 1'b1;
                    w_next = w_top;
                end
            end
            C_WAIT:   if (!uSequencer_MemReady_InHigh) w_next = r_addr;
            default:  w_next = w_inc;
        endcase
    end

    // Address, stack pointer and sticky error registers; reset overrides any call/return/wait.
    always_ff @(posedge uSequencer_CLOCK_50) begin
        if (uSequencer_Reset_InHigh) begin
            r_addr <= ADDR_WIDTH'(RESET_ADDR);
            r_sp   <= '0;
            r_err  <= 1'b0;
        end else begin
            r_addr <= w_next;
            if (w_push) r_sp <= r_sp + SP_WIDTH'(1);
            if (w_pop)  r_sp <= r_sp - SP_WIDTH'(1);
            if (w_err_set) r_err <= 1'b1;
        end
    end

    // Return-address storage; contents need no reset because the pointer defines validity.
    always_ff @(posedge uSequencer_CLOCK_50) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!uSequencer_Reset_InHigh && w_push && r_sp == SP_WIDTH'(i)) begin
                r_stack[i] <= w_inc;
            end
        end
    end

    assign uSequencer_CSAddr_Out       = r_addr;
    assign uSequencer_StackDepth_Out   = r_sp;
    assign uSequencer_StackErr_OutHigh = r_err;

endmodule

// File: tb/tb_usequencer_stack.sv
// Bench for usequencer_stack: directed microprogram steps, queue-based reference model checked every cycle.
// Inputs change on the falling edge; outputs and model are compared on the falling edge after each rising edge.
module tb_usequencer_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cond = 4'd0;
    logic [10:0] jump = 11'd0;
    logic        fn = 1'b0, fz = 1'b0, fv = 1'b0, fc = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [2:0]  op2 = 3'd0;
    logic [5:0]  op3 = 6'd0;
    logic        bit13 = 1'b0;
    logic        mrdy = 1'b0;
    logic [10:0] cs_addr;
    logic [2:0]  depth;
    logic        serr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // reference model state
    int m_addr = 0;
    int m_stk[$];
    bit m_err = 1'b0;

    usequencer_stack dut (
        .uSequencer_CLOCK_50         (clk),
        .uSequencer_Reset_InHigh     (rst),
        .uSequencer_Cond_In          (cond),
        .uSequencer_JumpAddr_In      (jump),
        .uSequencer_FlagN_In         (fn),
        .uSequencer_FlagZ_In         (fz),
        .uSequencer_FlagV_In         (fv),
        .uSequencer_FlagC_In         (fc),
        .uSequencer_IR_OP_In         (op),
        .uSequencer_IR_OP2_In        (op2),
        .uSequencer_IR_OP3_In        (op3),
        .uSequencer_IR_BIT13_In      (bit13),
        .uSequencer_MemReady_InHigh  (mrdy),
        .uSequencer_CSAddr_Out       (cs_addr),
        .uSequencer_StackDepth_Out   (depth),
        .uSequencer_StackErr_OutHigh (serr)
    );

    always #5 clk = ~clk;

    // Reference model: next address from the condition table, stack as a queue.
    always @(posedge clk) begin
        int inc;
        inc = (m_addr + 1) % 2048;
        if (rst) begin
            m_addr = 0;
            m_stk.delete();
            m_err  = 1'b0;
        end else begin
            case (int'(cond))
                1:  m_addr = fn    ? int'(jump) : inc;
                2:  m_addr = fz    ? int'(jump) : inc;
                3:  m_addr = fv    ? int'(jump) : inc;
                4:  m_addr = fc    ? int'(jump) : inc;
                5:  m_addr = bit13 ? int'(jump) : inc;
                6:  m_addr = int'(jump);
                7: begin
                    if (op >= 2)      m_addr = 1024 + int'(op) * 256 + int'(op3) * 4;
                    else if (op == 0) m_addr = 1024 + int'(op2) * 4;
                    else              m_addr = 1024 + 256;
                end
                8: begin
                    if (m_stk.size() < 4) begin
                        m_stk.push_back(inc);
                        m_addr = int'(jump);
                    end else begin
                        m_err  = 1'b1;
                        m_addr = inc;
                    end
                end
                9: begin
                    if (m_stk.size() > 0) begin
                        m_addr = m_stk.pop_back();
                    end else begin
                        m_err  = 1'b1;
                        m_addr = inc;
                    end
                end
                10: m_addr = mrdy ? inc : m_addr;
                default: m_addr = inc;
            endcase
        end
    end

    // Cycle-by-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (int'(cs_addr) !== m_addr) begin
                n_fail++;
                $display("FAIL model_addr t=%0t got=%h exp=%h", $time, cs_addr, m_addr);
            end
            n_tests++;
            if (int'(depth) !== m_stk.size()) begin
                n_fail++;
                $display("FAIL model_depth t=%0t got=%0d exp=%0d", $time, depth, m_stk.size());
            end
            n_tests++;
            if (serr !== m_err) begin
                n_fail++;
                $display("FAIL model_err t=%0t got=%0b exp=%0b", $time, serr, m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int a, input int d, input int e);
        chk({name, "_addr"},  int'(cs_addr), a);
        chk({name, "_depth"}, int'(depth),   d);
        chk({name, "_err"},   int'(serr),    e);
    endtask

    task automatic go(input logic [3:0] c, input logic [10:0] j);
        cond = c;
        jump = j;
        tick();
    endtask

    initial begin
        // reset
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        chk_all("reset", 0, 0, 0);
        rst = 1'b0;

        // sequential NEXT
        go(4'd0, 11'h0); chk("next1", int'(cs_addr), 1);
        go(4'd0, 11'h0); chk("next2", int'(cs_addr), 2);
        go(4'd0, 11'h0); chk("next3", int'(cs_addr), 3);

        // reset beats a call in progress
        rst = 1'b1;
        go(4'd8, 11'h100);
        chk_all("rst_over_call", 0, 0, 0);
        rst = 1'b0;

        // conditional jumps
        go(4'd6, 11'h005); chk("jump5", int'(cs_addr), 5);
        fz = 1'b1;
        go(4'd2, 11'h040); chk("jz_taken", int'(cs_addr), 'h40);
        fz = 1'b0;
        go(4'd6, 11'h005);
        go(4'd2, 11'h040); chk("jz_not", int'(cs_addr), 6);
        go(4'd6, 11'h005);
        bit13 = 1'b1;
        go(4'd5, 11'h040); chk("jir13", int'(cs_addr), 'h40);
        bit13 = 1'b0;
        fn = 1'b1;
        go(4'd1, 11'h077); chk("jn_taken", int'(cs_addr), 'h77);
        fn = 1'b0; fv = 1'b1;
        go(4'd1, 11'h020); chk("jn_not", int'(cs_addr), 'h78);
        go(4'd3, 11'h030); chk("jv_taken", int'(cs_addr), 'h30);
        fv = 1'b0;
        go(4'd4, 11'h050); chk("jc_not", int'(cs_addr), 'h31);
        fc = 1'b1;
        go(4'd4, 11'h050); chk("jc_taken", int'(cs_addr), 'h50);
        fc = 1'b0;

        // decode
        op = 2'd2; op3 = 6'h10;
        go(4'd7, 11'h0); chk("dec_op2", int'(cs_addr), 'h640);
        op = 2'd0; op2 = 3'd2;
        go(4'd7, 11'h0); chk("dec_op0", int'(cs_addr), 'h408);
        op = 2'd1;
        go(4'd7, 11'h0); chk("dec_op1", int'(cs_addr), 'h500);
        op = 2'd3; op3 = 6'h3F;
        go(4'd7, 11'h0); chk("dec_op3", int'(cs_addr), 'h7FC);

        // nested call / return
        go(4'd6, 11'h010);
        go(4'd8, 11'h100); chk_all("call1", 'h100, 1, 0);
        go(4'd8, 11'h200); chk_all("call2", 'h200, 2, 0);
        go(4'd9, 11'h000); chk_all("ret1",  'h101, 1, 0);
        go(4'd9, 11'h000); chk_all("ret2",  'h011, 0, 0);

        // overflow on the fifth call
        go(4'd8, 11'h300);
        go(4'd8, 11'h310);
        go(4'd8, 11'h320);
        go(4'd8, 11'h330); chk_all("call4", 'h330, 4, 0);
        go(4'd8, 11'h340); chk_all("call5_ovf", 'h331, 4, 1);
        go(4'd9, 11'h0); chk("pop_a", int'(cs_addr), 'h321);
        go(4'd9, 11'h0); chk("pop_b", int'(cs_addr), 'h311);
        go(4'd9, 11'h0); chk("pop_c", int'(cs_addr), 'h301);
        go(4'd9, 11'h0); chk_all("pop_d", 'h012, 0, 1);
        go(4'd9, 11'h0); chk_all("ret_empty", 'h013, 0, 1);

        // address wrap
        go(4'd6, 11'h7FF); chk("at_max", int'(cs_addr), 'h7FF);
        go(4'd0, 11'h0);   chk("wrap", int'(cs_addr), 0);

        // memory wait
        mrdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            go(4'd10, 11'h0);
            chk("wait_hold", int'(cs_addr), 0);
        end
        mrdy = 1'b1;
        go(4'd10, 11'h0); chk("wait_done", int'(cs_addr), 1);

        // reserved conditions behave as NEXT
        go(4'd11, 11'h3AA); chk("cond11", int'(cs_addr), 2);
        go(4'd15, 11'h3AA); chk("cond15", int'(cs_addr), 3);

        // reset clears the sticky error, even during WAIT
        rst = 1'b1; mrdy = 1'b0;
        go(4'd10, 11'h0);
        chk_all("rst_clr", 0, 0, 0);
        rst = 1'b0;

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
